// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: one value register shown across DIGITS
// displays, with static / blink / count-up / count-down modes and leading-zero blanking.

module hex_digit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] nib,
    input  logic       off,
    output logic [6:0] seg
);
    // Active-low segments, bit 6 = g ... bit 0 = a
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'b1000000;
            4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;
            4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;
            4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;
            4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0010000;
            4'ha: dec = 7'b0001000;
            4'hb: dec = 7'b0000011;
            4'hc: dec = 7'b1000110;
            4'hd: dec = 7'b0100001;
            4'he: dec = 7'b0000110;
            default: dec = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n)
            seg <= 7'h7f;
        else if (off)
            seg <= 7'h7f;
        else
            seg <= dec(nib);
    end
endmodule

module hex_display_ctrl #(
    parameter int DIGITS = 6,
    parameter int TICK   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   hex,
    output logic [4*DIGITS-1:0]   shown,
    output logic                  tick
);
    localparam int VW = 4 * DIGITS;
    localparam int CW = $clog2(TICK);

    logic [VW-1:0]     val;
    logic [1:0]        mode_r;
    logic [CW-1:0]     cnt;
    logic              phase;
    logic              dark;
    logic [DIGITS-1:0] upper_zero;

    assign tick  = (cnt == CW'(TICK - 1));
    assign shown = val;
    assign dark  = (mode_r == 2'b01) && !phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val    <= '0;
            mode_r <= 2'b00;
            cnt    <= '0;
            phase  <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            // A load restarts the tick interval and swallows a coincident tick
            if (load) begin
                val    <= value;
                mode_r <= mode;
                cnt    <= '0;
                phase  <= 1'b1;
            end else begin
                if (tick) begin
                    case (mode_r)
                        2'b10:   val <= val + 1'b1;
                        2'b11:   val <= val - 1'b1;
                        default: ;
                    endcase
                end
                phase <= (mode_r == 2'b01) ? (phase ^ tick) : 1'b1;
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            logic off;
            assign upper_zero[i] = (val[VW-1:4*i] == '0);
            if (i == 0) begin : g_lsd
                assign off = dark;
            end else begin : g_upper
                assign off = dark | (blank_lz & upper_zero[i]);
            end
            hex_digit u_dig (
                .clk     (clk),
                .reset_n (reset_n),
                .nib     (val[4*i +: 4]),
                .off     (off),
                .seg     (hex[7*i +: 7])
            );
        end
    endgenerate
endmodule
